// File: rtl/a_trace_buf_ctrl_if.sv
// Trace-buffer controller bus bundle: DUT trace tap, trace RAM ports and host readback.
// The controller connects through the slave modport; its environment uses master.
interface a_trace_buf_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13
);
    logic              soft_init_i;
    logic              mode_wrap_i;
    logic              enable_trace_i;
    logic              capt_i;
    logic [DATA_W-1:0] data_dut_i;
    logic              wr_load_i;
    logic              rd_load_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic              rd_req_i;
    logic              busi_i;
    logic [DATA_W-1:0] data_read_i;
    logic              wen_o;
    logic [ADDR_W-1:0] wraddr_o;
    logic [ADDR_W-1:0] rdaddr_o;
    logic [DATA_W-1:0] data_o;
    logic [15:0]       data_rd_o;
    logic              r_dv_trce_o;
    logic [ADDR_W:0]   level_o;
    logic              stop_verification_trce_o;
    logic              wrapped_o;
    logic              overflow_o;

    modport master (
        output soft_init_i, mode_wrap_i, enable_trace_i, capt_i, data_dut_i,
               wr_load_i, rd_load_i, load_addr_i, rd_req_i, busi_i, data_read_i,
        input  wen_o, wraddr_o, rdaddr_o, data_o, data_rd_o, r_dv_trce_o,
               level_o, stop_verification_trce_o, wrapped_o, overflow_o
    );

    modport slave (
        input  soft_init_i, mode_wrap_i, enable_trace_i, capt_i, data_dut_i,
               wr_load_i, rd_load_i, load_addr_i, rd_req_i, busi_i, data_read_i,
        output wen_o, wraddr_o, rdaddr_o, data_o, data_rd_o, r_dv_trce_o,
               level_o, stop_verification_trce_o, wrapped_o, overflow_o
    );
endinterface

// File: rtl/a_trace_buf_ctrl.sv
// Trace-buffer controller: captures trace words into an external RAM (stop or wrap mode)
// and drains stored words to the host as 16-bit chunks under busy flow control.
module a_trace_buf_ctrl #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 13,
    parameter int FULL_MARGIN = 10
) (
    input  logic              clk_ref,
    input  logic              rst,
    a_trace_buf_ctrl_if.slave bus
);
    localparam int NCHUNK = DATA_W / 16;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]   LAST_K   = CW'(NCHUNK - 1);
    localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] STOP_THR = LVL_FULL - (ADDR_W + 1)'(FULL_MARGIN);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_SEND} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] wptr, rptr, wptr_d, rptr_d;
    logic [ADDR_W:0]   level, level_d;
    logic [CW-1:0]     kidx;
    logic [DATA_W-1:0] chunk_q;
    logic              wen, r_dv, stop, wrapped, overflow;
    logic [ADDR_W-1:0] wraddr;
    logic [DATA_W-1:0] data_w;
    logic [15:0]       data_rd;

    logic load, capt_try, capt_block, capt_acc, overwrite, send_go, retire, idle_empty;

    always_ff @(posedge clk_ref) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.soft_init_i || load) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.rd_req_i && level != '0) state_d = S_FETCH;
                S_FETCH: state_d = S_LATCH;
                S_LATCH: state_d = S_SEND;
                S_SEND:  if (retire) state_d = (bus.rd_req_i && level != LVL_ONE) ? S_FETCH : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Full in wrap mode only overwrites while no word is being read out.
    always_comb begin
        load       = bus.wr_load_i | bus.rd_load_i;
        capt_try   = bus.enable_trace_i & bus.capt_i;
        capt_block = (!bus.mode_wrap_i && level >= STOP_THR) ||
                     (level == LVL_FULL && (!bus.mode_wrap_i || state_q != S_IDLE));
        capt_acc   = capt_try && !capt_block && !load;
        overwrite  = capt_acc && (level == LVL_FULL);
        send_go    = (state_q == S_SEND) && !bus.busi_i;
        retire     = send_go && (kidx == LAST_K);
        idle_empty = (state_q == S_IDLE) && (level == '0) && !capt_acc;

        wptr_d  = wptr;
        rptr_d  = rptr;
        level_d = level;
        if (bus.wr_load_i) begin
            wptr_d  = bus.load_addr_i;
            level_d = {1'b0, bus.load_addr_i - rptr};
        end else if (bus.rd_load_i) begin
            rptr_d  = bus.load_addr_i;
            level_d = {1'b0, wptr - bus.load_addr_i};
        end else if (idle_empty) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (capt_acc)             wptr_d = wptr + ADDR_W'(1);
            if (retire || overwrite)  rptr_d = rptr + ADDR_W'(1);
            if (capt_acc && !overwrite && !retire) level_d = level + LVL_ONE;
            else if (retire && !capt_acc)          level_d = level - LVL_ONE;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst || bus.soft_init_i) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            kidx     <= '0;
            chunk_q  <= '0;
            wen      <= 1'b0;
            r_dv     <= 1'b0;
            stop     <= 1'b0;
            wrapped  <= 1'b0;
            overflow <= 1'b0;
            wraddr   <= '0;
            data_w   <= '0;
            data_rd  <= '0;
        end else begin
            wptr  <= wptr_d;
            rptr  <= rptr_d;
            level <= level_d;
            stop  <= !bus.mode_wrap_i && (level_d >= STOP_THR);
            wen   <= capt_acc;
            r_dv  <= 1'b0;
            if (load) begin
                wrapped <= 1'b0;
                kidx    <= '0;
            end else begin
                if (capt_try && capt_block) overflow <= 1'b1;
                if (overwrite)              wrapped  <= 1'b1;
                if (capt_acc) begin
                    data_w <= bus.data_dut_i;
                    wraddr <= wptr;
                end
                // Chunk register shifts down so the LSB chunk always leaves first.
                if (state_q == S_LATCH) begin
                    chunk_q <= bus.data_read_i;
                    kidx    <= '0;
                end else if (send_go) begin
                    data_rd <= chunk_q[15:0];
                    chunk_q <= chunk_q >> 16;
                    r_dv    <= 1'b1;
                    kidx    <= kidx + CW'(1);
                end
            end
        end
    end

    assign bus.wen_o                    = wen;
    assign bus.wraddr_o                 = wraddr;
    assign bus.rdaddr_o                 = rptr;
    assign bus.data_o                   = data_w;
    assign bus.data_rd_o                = data_rd;
    assign bus.r_dv_trce_o              = r_dv;
    assign bus.level_o                  = level;
    assign bus.stop_verification_trce_o = stop;
    assign bus.wrapped_o                = wrapped;
    assign bus.overflow_o               = overflow;
endmodule
